mem_arbiter: RTL and testbench

Two-port arbiter that shares the single slow-memory interface (128-bit line, 28-bit line address, read/write/ready handshake) between the instruction cache (port I) and the data cache (port D). It sits between both caches and the memory model or controller. It grants one whole line transaction at a time, using round-robin priority. It also absorbs the caches' one-cycle request tail after `ready`.

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arbiter_rr_arb2.sv | 22 ++
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the I/D cache memory arbiter and the caches that connect to it.
package mem_arbiter_pkg;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;

  localparam int PORT_I = 0;
  localparam int PORT_D = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GNT_I   = 2'd1,
    ST_GNT_D   = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  function automatic logic is_req(input logic rd, input logic wr);
    return rd | wr;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-requester round-robin picker: on a tie the port that was not served last wins.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req[PORT_I] && req[PORT_D]) begin
      if (last_gnt == 1'(PORT_D)) gnt[PORT_I] = 1'b1;
      else                        gnt[PORT_D] = 1'b1;
    end else if (req[PORT_I]) begin
      gnt[PORT_I] = 1'b1;
    end else if (req[PORT_D]) begin
      gnt[PORT_D] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one line-wide memory interface between the I-cache and D-cache, one whole
// transaction at a time, with round-robin priority and a one-cycle release gap.
//
//   state      | meaning
//   -----------+--------------------------------------------------------------
//   ST_IDLE    | no owner; arbitrate between pending requests
//   ST_GNT_I   | port I owns memory until mem_ready
//   ST_GNT_D   | port D owns memory until mem_ready
//   ST_RELEASE | swallow the requesting cache's one-cycle tail after ready
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              proto_err
);

  arb_state_e state_q, state_d;
  logic       last_gnt_q, last_gnt_d;
  logic       proto_err_q, proto_err_d;

  logic [1:0] req;
  logic [1:0] gnt;

  logic              gnt_active;
  logic              sel_d;
  logic              sel_read;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign req[PORT_I] = is_req(i_read, i_write);
  assign req[PORT_D] = is_req(d_read, d_write);

  rr_arb2 u_rr_arb2 (
    .req      (req),
    .last_gnt (last_gnt_q),
    .gnt      (gnt)
  );

  // Read data is broadcast; only the owner's ready qualifies it.
  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign proto_err = proto_err_q;

  always_comb begin
    gnt_active = (state_q == ST_GNT_I) || (state_q == ST_GNT_D);
    sel_d      = (state_q == ST_GNT_D);
    sel_read   = sel_d ? d_read  : i_read;
    sel_write  = sel_d ? d_write : i_write;
    sel_addr   = sel_d ? d_addr  : i_addr;
    sel_wdata  = sel_d ? d_wdata : i_wdata;
  end

  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    proto_err_d = proto_err_q;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    i_ready     = 1'b0;
    d_ready     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (gnt[PORT_I])      state_d = ST_GNT_I;
        else if (gnt[PORT_D]) state_d = ST_GNT_D;
      end

      ST_GNT_I, ST_GNT_D: begin
        // A dropped request zeroes the bus but keeps the grant; memory is never aborted.
        if (sel_read || sel_write) begin
          mem_write = sel_write;
          mem_read  = sel_read & ~sel_write;
          mem_addr  = sel_addr;
          mem_wdata = sel_wdata;
        end
        if (sel_read && sel_write) proto_err_d = 1'b1;
        if (mem_ready) begin
          i_ready    = ~sel_d;
          d_ready    = sel_d;
          last_gnt_d = sel_d ? 1'(PORT_D) : 1'(PORT_I);
          state_d    = ST_RELEASE;
        end
      end

      ST_RELEASE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    if (!gnt_active) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_q     <= ST_IDLE;
      last_gnt_q  <= 1'(PORT_D);
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a transaction-level owner/gap model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic              clk = 1'b0;
  logic              proc_reset_n = 1'b0;
  logic              i_read = 1'b0, i_write = 1'b0, d_read = 1'b0, d_write = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0, d_addr = '0;
  logic [DATA_W-1:0] i_wdata = '0, d_wdata = '0, mem_rdata = '0;
  logic              mem_ready = 1'b0;
  logic [DATA_W-1:0] i_rdata, d_rdata, mem_wdata;
  logic              i_ready, d_ready, mem_read, mem_write, proto_err;
  logic [ADDR_W-1:0] mem_addr;

  int checks = 0;
  int failures = 0;

  // Reference: who owns memory (0 none, 1 I, 2 D), cycles of post-ready gap left,
  // whether D was served last, and the sticky error flag.
  int m_owner = 0;
  int m_gap = 0;
  bit m_last_d = 1'b1;
  bit m_err = 1'b0;

  logic              obs_rd, obs_wr, obs_busy, obs_ir, obs_dr, obs_perr;
  logic [ADDR_W-1:0] obs_addr;
  logic [DATA_W-1:0] obs_wd;
  logic [1:0]        who;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk          (clk),
    .proc_reset_n (proc_reset_n),
    .i_read       (i_read),
    .i_write      (i_write),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .i_rdata      (i_rdata),
    .i_ready      (i_ready),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_ready      (d_ready),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready)
    ,.proto_err   (proto_err)
  );

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0;
    m_gap = 0;
    m_last_d = 1'b1;
    m_err = 1'b0;
  endtask

  // Called at posedge+1 with this cycle's inputs applied; checks, crosses one edge, returns at posedge+1.
  task automatic tick();
    logic              e_rd, e_wr, e_ir, e_dr, p_rd, p_wr, ireq, dreq;
    logic [ADDR_W-1:0] e_addr, p_addr;
    logic [DATA_W-1:0] e_wd, p_wd;
    #1;
    e_rd = 1'b0; e_wr = 1'b0; e_ir = 1'b0; e_dr = 1'b0;
    e_addr = '0; e_wd = '0;
    p_rd   = (m_owner == 2) ? d_read  : i_read;
    p_wr   = (m_owner == 2) ? d_write : i_write;
    p_addr = (m_owner == 2) ? d_addr  : i_addr;
    p_wd   = (m_owner == 2) ? d_wdata : i_wdata;
    if (proc_reset_n && m_owner != 0) begin
      if (p_rd || p_wr) begin
        e_wr = p_wr;
        e_rd = p_rd & ~p_wr;
        e_addr = p_addr;
        e_wd = p_wd;
      end
      if (mem_ready) begin
        e_ir = (m_owner == 1);
        e_dr = (m_owner == 2);
      end
    end
    obs_rd = mem_read; obs_wr = mem_write; obs_busy = mem_read | mem_write;
    obs_ir = i_ready; obs_dr = d_ready; obs_perr = proto_err;
    obs_addr = mem_addr; obs_wd = mem_wdata;
    chk("mem_read",  DATA_W'(mem_read),  DATA_W'(e_rd));
    chk("mem_write", DATA_W'(mem_write), DATA_W'(e_wr));
    chk("mem_addr",  DATA_W'(mem_addr),  DATA_W'(e_addr));
    chk("mem_wdata", mem_wdata, e_wd);
    chk("i_ready",   DATA_W'(i_ready),   DATA_W'(e_ir));
    chk("d_ready",   DATA_W'(d_ready),   DATA_W'(e_dr));
    chk("proto_err", DATA_W'(proto_err), DATA_W'(m_err));
    chk("i_rdata",   i_rdata, mem_rdata);
    chk("d_rdata",   d_rdata, mem_rdata);
    @(posedge clk);
    ireq = i_read | i_write;
    dreq = d_read | d_write;
    if (!proc_reset_n) begin
      model_reset();
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (m_owner != 0) begin
      if (p_rd && p_wr) m_err = 1'b1;
      if (mem_ready) begin
        m_last_d = (m_owner == 2);
        m_owner = 0;
        m_gap = 1;
      end
    end else if (ireq && (!dreq || m_last_d)) begin
      m_owner = 1;
    end else if (dreq) begin
      m_owner = 2;
    end
    #1;
  endtask

  task automatic apply_reset();
    proc_reset_n = 1'b0;
    model_reset();
    i_read = 1'b0; i_write = 1'b0; d_read = 1'b0; d_write = 1'b0;
    mem_ready = 1'b0;
    tick();
    tick();
    proc_reset_n = 1'b1;
  endtask

  // Wait for a visible grant, hold it lat cycles, then return ready; reports which port saw ready.
  task automatic serve(input int lat, output logic [1:0] w);
    int guard;
    guard = 0;
    w = 2'd3;
    do begin
      tick();
      guard++;
    end while (!obs_busy && guard < 12);
    chk("grant_timeout", DATA_W'(obs_busy), DATA_W'(1'b1));
    for (int k = 1; k < lat; k++) tick();
    mem_ready = 1'b1;
    tick();
    if (obs_ir && !obs_dr)      w = 2'd0;
    else if (obs_dr && !obs_ir) w = 2'd1;
    mem_ready = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    apply_reset();

    // D-only read, ready 8 cycles after the request.
    d_read = 1'b1; d_addr = 28'h0000123;
    tick();
    chk("t1_cycle0_idle", DATA_W'(obs_rd), DATA_W'(1'b0));
    tick();
    chk("t1_cycle1_read", DATA_W'(obs_rd), DATA_W'(1'b1));
    chk("t1_cycle1_addr", DATA_W'(obs_addr), DATA_W'(28'h0000123));
    for (int k = 0; k < 6; k++) tick();
    mem_ready = 1'b1;
    mem_rdata = {16{8'hA5}};
    tick();
    chk("t1_d_ready", DATA_W'(obs_dr), DATA_W'(1'b1));
    chk("t1_i_ready", DATA_W'(obs_ir), DATA_W'(1'b0));
    chk("t1_d_rdata", d_rdata, {16{8'hA5}});
    mem_ready = 1'b0;
    tick();
    chk("t1_ready_pulse", DATA_W'(obs_dr), DATA_W'(1'b0));
    d_read = 1'b0;
    tick();

    // Simultaneous I read / D write out of reset: I first, D three cycles after I's ready.
    apply_reset();
    i_read = 1'b1; i_addr = 28'h0000040;
    d_write = 1'b1; d_addr = 28'h0000080;
    d_wdata = {$urandom, $urandom, $urandom, $urandom};
    serve(2, who);
    chk("t2_first_is_i", DATA_W'(who), DATA_W'(2'd0));
    tick();
    chk("t2_gap1", DATA_W'(obs_busy), DATA_W'(1'b0));
    i_read = 1'b0;
    tick();
    chk("t2_gap2", DATA_W'(obs_busy), DATA_W'(1'b0));
    tick();
    chk("t2_d_write", DATA_W'(obs_wr), DATA_W'(1'b1));
    chk("t2_d_addr", DATA_W'(obs_addr), DATA_W'(28'h0000080));
    chk("t2_d_wdata", obs_wd, d_wdata);
    serve(1, who);
    chk("t2_second_is_d", DATA_W'(who), DATA_W'(2'd1));
    d_write = 1'b0;
    tick();

    // Continuous requests from both ports alternate.
    apply_reset();
    i_read = 1'b1; d_read = 1'b1;
    for (int t = 0; t < 4; t++) begin
      i_addr = ADDR_W'($urandom);
      d_addr = ADDR_W'($urandom);
      serve(2, who);
      chk("t3_alternate", DATA_W'(who), DATA_W'(t % 2));
    end
    i_read = 1'b0; d_read = 1'b0;
    tick();

    // D write-back, then D refill, with I requesting in between.
    apply_reset();
    d_write = 1'b1; d_addr = 28'h00000C0;
    d_wdata = {$urandom, $urandom, $urandom, $urandom};
    tick();
    i_read = 1'b1; i_addr = 28'h0000200;
    serve(3, who);
    chk("t4_first_d_wr", DATA_W'(who), DATA_W'(2'd1));
    tick();
    d_write = 1'b0; d_read = 1'b1; d_addr = 28'h0000300;
    serve(2, who);
    chk("t4_then_i", DATA_W'(who), DATA_W'(2'd0));
    tick();
    i_read = 1'b0;
    serve(2, who);
    chk("t4_then_d_rd", DATA_W'(who), DATA_W'(2'd1));
    tick();
    d_read = 1'b0;
    tick();

    // Read and write together while D is granted.
    apply_reset();
    d_write = 1'b1; d_addr = 28'h0000444;
    tick();
    d_read = 1'b1;
    tick();
    chk("t5_write_fwd", DATA_W'(obs_wr), DATA_W'(1'b1));
    chk("t5_read_supp", DATA_W'(obs_rd), DATA_W'(1'b0));
    tick();
    chk("t5_err_set", DATA_W'(obs_perr), DATA_W'(1'b1));
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    d_read = 1'b0; d_write = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("t5_err_sticky", DATA_W'(obs_perr), DATA_W'(1'b1));
    proc_reset_n = 1'b0;
    model_reset();
    tick();
    chk("t5_err_cleared", DATA_W'(obs_perr), DATA_W'(1'b0));
    proc_reset_n = 1'b1;
    tick();

    // Reset three cycles into a D transaction, then a late mem_ready.
    d_read = 1'b1; d_addr = 28'h0000555;
    tick();
    for (int k = 0; k < 3; k++) tick();
    proc_reset_n = 1'b0;
    model_reset();
    tick();
    chk("t6_bus_zero", DATA_W'(obs_busy), DATA_W'(1'b0));
    mem_ready = 1'b1;
    tick();
    chk("t6_no_ready_rst", DATA_W'(obs_dr), DATA_W'(1'b0));
    d_read = 1'b0;
    proc_reset_n = 1'b1;
    tick();
    chk("t6_no_ready_idle", DATA_W'(obs_dr), DATA_W'(1'b0));
    mem_ready = 1'b0;
    d_read = 1'b1;
    tick();
    tick();
    chk("t6_regrant", DATA_W'(obs_rd), DATA_W'(1'b1));
    serve(1, who);
    chk("t6_serve_d", DATA_W'(who), DATA_W'(2'd1));
    d_read = 1'b0;
    tick();

    // Randomized traffic against the reference model.
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      i_read    = ($urandom_range(0, 2) != 0);
      i_write   = ($urandom_range(0, 15) == 0);
      d_read    = ($urandom_range(0, 2) == 0);
      d_write   = ($urandom_range(0, 2) == 0) && (c > 300 || !d_read);
      i_addr    = ADDR_W'($urandom);
      d_addr    = ADDR_W'($urandom);
      i_wdata   = {$urandom, $urandom, $urandom, $urandom};
      d_wdata   = {$urandom, $urandom, $urandom, $urandom};
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      mem_ready = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
